rx_parity_checker: RTL and testbench

- Receive-side counterpart of the TX parity generator in the UART core.
- Takes sampled RX bits, one per strobe from the RX baud sampler, and assembles the data byte LSB-first.
- Accumulates parity bit-serially, checks it against the received parity bit, and checks the stop bit.
- Presents the byte with a one-cycle valid pulse, parity/frame error flags and a saturating parity-error counter.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/rx_sat_counter.sv | 20 ++
 rtl/rx_parity_checker.sv | 134 +++++++++++++
 tb/tb_rx_parity_checker.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared encodings for the UART receive path: one-hot FSM states and
// parity configuration constants.
package uart_rx_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    DATA   = 4'b0010,
    PARITY = 4'b0100,
    STOP   = 4'b1000
  } rx_state_e;

  localparam logic EVEN    = 1'b0;
  localparam logic ODD     = 1'b1;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  // Wide enough to count up to the largest supported frame (8 data bits).
  localparam int BIT_CNT_W = 4;

endpackage

// File: rtl/rx_sat_counter.sv
// Saturating up-counter; clear dominates a simultaneous increment.
module rx_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/rx_parity_checker.sv
// UART RX byte assembler with bit-serial parity and stop-bit checking.
// Define RX_BREAK_DETECT_EN to add the p_Break_o all-zero-frame pulse.
module rx_parity_checker
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  p_FrameStart_i,
  input  logic                  p_BitStrobe_i,
  input  logic                  BitValue_i,
  input  logic                  ParityEnable_i,
  input  logic                  ParityMethod_i,
  input  logic                  ClearCnt_i,
  output logic [DATA_WIDTH-1:0] Data_o,
  output logic                  p_DataValid_o,
  output logic                  ParityErr_o,
  output logic                  FrameErr_o,
  output logic                  Busy_o,
  output logic [CNT_W-1:0]      ParityErrCnt_o
`ifdef RX_BREAK_DETECT_EN
  ,
  output logic                  p_Break_o
`endif
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  rx_state_e             state, state_next;
  logic [DATA_WIDTH-1:0] shift_r;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  acc;
  logic                  par_en_r;
  logic                  par_odd_r;
  logic                  par_err_r;
`ifdef RX_BREAK_DETECT_EN
  logic                  all_zero_r;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first, so a branch that does not assign cannot infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (p_FrameStart_i) state_next = DATA;
      DATA:    if (p_BitStrobe_i && (bit_cnt == LAST_BIT))
                 state_next = (par_en_r == ENABLE) ? PARITY : STOP;
      PARITY:  if (p_BitStrobe_i) state_next = STOP;
      STOP:    if (p_BitStrobe_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign Busy_o = (state != IDLE);

  // NOTE: non-blocking assignments, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r       <= '0;
      bit_cnt       <= '0;
      acc           <= 1'b0;
      par_en_r      <= DISABLE;
      par_odd_r     <= EVEN;
      par_err_r     <= 1'b0;
      Data_o        <= '0;
      p_DataValid_o <= 1'b0;
      ParityErr_o   <= 1'b0;
      FrameErr_o    <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
      all_zero_r    <= 1'b0;
      p_Break_o     <= 1'b0;
`endif
    end else begin
      p_DataValid_o <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
      p_Break_o     <= 1'b0;
`endif
      unique case (state)
        IDLE: if (p_FrameStart_i) begin
          // Configuration is frozen here for the whole frame.
          par_en_r   <= ParityEnable_i;
          par_odd_r  <= ParityMethod_i;
          acc        <= 1'b0;
          bit_cnt    <= '0;
          par_err_r  <= 1'b0;
`ifdef RX_BREAK_DETECT_EN
          all_zero_r <= 1'b1;
`endif
        end
        DATA: if (p_BitStrobe_i) begin
          shift_r    <= {BitValue_i, shift_r[DATA_WIDTH-1:1]};
          acc        <= acc ^ BitValue_i;
          bit_cnt    <= bit_cnt + 1'b1;
`ifdef RX_BREAK_DETECT_EN
          all_zero_r <= all_zero_r & ~BitValue_i;
`endif
        end
        PARITY: if (p_BitStrobe_i) begin
          par_err_r  <= BitValue_i != (acc ^ par_odd_r);
`ifdef RX_BREAK_DETECT_EN
          all_zero_r <= all_zero_r & ~BitValue_i;
`endif
        end
        STOP: if (p_BitStrobe_i) begin
          Data_o        <= shift_r;
          ParityErr_o   <= par_en_r & par_err_r;
          FrameErr_o    <= ~BitValue_i;
          p_DataValid_o <= 1'b1;
`ifdef RX_BREAK_DETECT_EN
          p_Break_o     <= all_zero_r & ~BitValue_i;
`endif
        end
        default: ;
      endcase
    end
  end

  rx_sat_counter #(
    .CNT_W (CNT_W)
  ) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (p_DataValid_o & ParityErr_o),
    .clear (ClearCnt_i),
    .count (ParityErrCnt_o)
  );

endmodule

// File: tb/tb_rx_parity_checker.sv
// Scoreboard bench for rx_parity_checker: frames push expectations, a
// monitor pops and compares them on each valid pulse.
module tb_rx_parity_checker;

  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          p_FrameStart_i;
  logic          p_BitStrobe_i;
  logic          BitValue_i;
  logic          ParityEnable_i;
  logic          ParityMethod_i;
  logic          ClearCnt_i;
  logic [DW-1:0] Data_o;
  logic          p_DataValid_o;
  logic          ParityErr_o;
  logic          FrameErr_o;
  logic          Busy_o;
  logic [CW-1:0] ParityErrCnt_o;
`ifdef RX_BREAK_DETECT_EN
  logic          p_Break_o;
`endif

  rx_parity_checker #(
    .DATA_WIDTH (DW),
    .CNT_W      (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .p_FrameStart_i (p_FrameStart_i),
    .p_BitStrobe_i  (p_BitStrobe_i),
    .BitValue_i     (BitValue_i),
    .ParityEnable_i (ParityEnable_i),
    .ParityMethod_i (ParityMethod_i),
    .ClearCnt_i     (ClearCnt_i),
    .Data_o         (Data_o),
    .p_DataValid_o  (p_DataValid_o),
    .ParityErr_o    (ParityErr_o),
    .FrameErr_o     (FrameErr_o),
    .Busy_o         (Busy_o),
    .ParityErrCnt_o (ParityErrCnt_o)
`ifdef RX_BREAK_DETECT_EN
    ,
    .p_Break_o      (p_Break_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
    logic          brk;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   pulses = 0;
  int   frames = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: every valid pulse must match the oldest pending expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (p_DataValid_o === 1'b1) begin
        pulses++;
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("data",       32'(Data_o),      32'(mon_e.data));
          check("parity_err", 32'(ParityErr_o), 32'(mon_e.perr));
          check("frame_err",  32'(FrameErr_o),  32'(mon_e.ferr));
`ifdef RX_BREAK_DETECT_EN
          check("break",      32'(p_Break_o),   32'(mon_e.brk));
`endif
        end
      end
    end
  end

  task automatic strobe(input logic b);
    @(negedge clk);
    BitValue_i    = b;
    p_BitStrobe_i = 1'b1;
    @(negedge clk);
    p_BitStrobe_i = 1'b0;
    BitValue_i    = 1'b0;
  endtask

  task automatic start_frame(input logic en, input logic m, input logic coinc);
    @(negedge clk);
    p_FrameStart_i = 1'b1;
    ParityEnable_i = en;
    ParityMethod_i = m;
    if (coinc) begin
      p_BitStrobe_i = 1'b1;
      BitValue_i    = 1'b1;
    end
    @(negedge clk);
    p_FrameStart_i = 1'b0;
    p_BitStrobe_i  = 1'b0;
    BitValue_i     = 1'b0;
    check("busy_after_start", 32'(Busy_o), 32'd1);
    // Flip the config inputs: the frame must keep the latched values.
    ParityEnable_i = ~en;
    ParityMethod_i = ~m;
  endtask

  // Returns at the negedge of the valid-pulse cycle.
  task automatic send_frame(input logic [DW-1:0] d, input logic en, input logic m,
                            input logic pbit, input logic stop,
                            input logic coinc, input logic mid_start);
    exp_t e;
    e.data = d;
    e.perr = en & (pbit != ((^d) ^ m));
    e.ferr = ~stop;
    e.brk  = (d == '0) && (!en || !pbit) && !stop;
    sb.push_back(e);
    frames++;
    start_frame(en, m, coinc);
    for (int i = 0; i < DW; i++) begin
      strobe(d[i]);
      if (mid_start && i == 3) begin
        @(negedge clk);
        p_FrameStart_i = 1'b1;
        @(negedge clk);
        p_FrameStart_i = 1'b0;
      end
    end
    if (en) strobe(pbit);
    strobe(stop);
    check("valid_timing", 32'(p_DataValid_o), 32'd1);
    check("idle_after_stop", 32'(Busy_o), 32'd0);
  endtask

  task automatic after_frame(input int exp_cnt);
    @(negedge clk);
    check("valid_width", 32'(p_DataValid_o), 32'd0);
    check("err_cnt", 32'(ParityErrCnt_o), 32'(exp_cnt));
  endtask

  initial begin
    int cnt_model;
    int pulses_before;
    logic [DW-1:0] d;

    rst            = 1'b1;
    p_FrameStart_i = 1'b0;
    p_BitStrobe_i  = 1'b0;
    BitValue_i     = 1'b0;
    ParityEnable_i = 1'b0;
    ParityMethod_i = 1'b0;
    ClearCnt_i     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",  32'(Data_o),         32'd0);
    check("rst_valid", 32'(p_DataValid_o),  32'd0);
    check("rst_perr",  32'(ParityErr_o),    32'd0);
    check("rst_ferr",  32'(FrameErr_o),     32'd0);
    check("rst_busy",  32'(Busy_o),         32'd0);
    check("rst_cnt",   32'(ParityErrCnt_o), 32'd0);
    rst = 1'b0;

    // Even parity, good frame.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    after_frame(0);

    // Odd parity with the wrong parity bit, then a good frame.
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    after_frame(1);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    after_frame(1);

    // Parity disabled, stop bit low.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    after_frame(1);

    // Bad-parity frames until the 2-bit counter saturates.
    cnt_model = 1;
    for (int i = 0; i < 5; i++) begin
      d = 8'h11 + 8'(i);
      send_frame(d, 1'b1, 1'b0, ~(^d), 1'b1, 1'b0, 1'b0);
      if (cnt_model < 3) cnt_model++;
      after_frame(cnt_model);
    end

    // Clear coincident with another error's valid pulse.
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    ClearCnt_i = 1'b1;
    @(negedge clk);
    ClearCnt_i = 1'b0;
    check("clear_priority", 32'(ParityErrCnt_o), 32'd0);

    // Reset after four data strobes aborts the frame.
    pulses_before = pulses;
    start_frame(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(Busy_o), 32'd0);
    check("abort_data", 32'(Data_o), 32'd0);
    repeat (4) @(negedge clk);
    check("abort_no_valid", 32'(pulses), 32'(pulses_before));
    send_frame(8'h5A, 1'b1, 1'b0, ^8'h5A, 1'b1, 1'b0, 1'b0);
    after_frame(0);

    // Strobe with the start pulse and a start pulse mid-frame are ignored.
    send_frame(8'hC3, 1'b1, 1'b1, (^8'hC3) ^ 1'b1, 1'b1, 1'b1, 1'b1);
    after_frame(0);

`ifdef RX_BREAK_DETECT_EN
    send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    after_frame(0);
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("pulse_total", 32'(pulses), 32'(frames));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
